// File: rtl/ccff_chain_loader.sv
`timescale 1ns/1ps
// ccff_chain_loader
// Serialises 32-bit host bitstream words into the configuration chain head,
// one bit per enabled prog_clk cycle. Bits returned on the chain tail are
// packed back into 32-bit readback words. The I/O tiles are held isolated
// for the whole session and released only once the chain is fully loaded.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int ISO_CYC   = 4,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic        prog_clk,
    input  logic        prog_reset,
    input  logic        start,
    input  logic [31:0] cfg_data,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    output logic        ccff_head,
    output logic        chain_clk_en,
    input  logic        ccff_tail,
    output logic [31:0] rb_data,
    output logic        rb_valid,
    output logic        IO_ISOL_N,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Words needed to cover the chain, and bits carried by the final word.
    localparam int NUM_WORDS = (CHAIN_LEN + 31) / 32;
    localparam int LAST_BITS = ((CHAIN_LEN - 1) % 32) + 1;
    localparam int RB_PAD    = 32 - LAST_BITS;
    localparam int WC_W      = $clog2(NUM_WORDS + 1);
    localparam int ISO_W     = (ISO_CYC > 1) ? $clog2(ISO_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISO_PRE,
        S_SHIFT,
        S_ISO_POST
    } state_t;

    state_t            r_state;
    logic [ISO_W-1:0]  r_iso_cnt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WC_W-1:0]   r_words;
    logic [5:0]        r_rem;
    logic [31:0]       r_sr;
    logic [31:0]       r_rb;
    logic [4:0]        r_rb_pos;
    logic [31:0]       r_rb_data;
    logic              r_rb_valid;
    logic              r_iso_n;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_in_shift;
    logic              w_clk_en;
    logic              w_ready;
    logic              w_load;
    logic              w_last_shift;
    logic              w_new_session;
    logic              w_iso_last;
    logic [5:0]        w_load_bits;
    logic [31:0]       w_rb_word;

    assign w_in_shift    = (r_state == S_SHIFT);
    assign w_clk_en      = w_in_shift && (r_rem != 6'd0);
    // A new word may be taken when the shift register is empty or is
    // emitting its last bit this cycle, so back-to-back words never bubble.
    assign w_ready       = w_in_shift && (r_words < WC_W'(NUM_WORDS)) && (r_rem <= 6'd1);
    assign w_load        = w_ready && cfg_valid;
    assign w_last_shift  = w_clk_en && (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign w_new_session = (r_state == S_IDLE) && start;
    assign w_iso_last    = (r_iso_cnt == ISO_W'(ISO_CYC - 1));
    assign w_load_bits   = (r_words == WC_W'(NUM_WORDS - 1)) ? 6'(LAST_BITS) : 6'd32;
    assign w_rb_word     = {r_rb[30:0], ccff_tail};

    assign cfg_ready     = w_ready;
    assign chain_clk_en  = w_clk_en;
    assign ccff_head     = r_sr[31];
    assign rb_data       = r_rb_data;
    assign rb_valid      = r_rb_valid;
    assign IO_ISOL_N     = r_iso_n;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

    // Session sequencing: isolation guard, shifting, guard, release.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            r_state   <= S_IDLE;
            r_iso_cnt <= '0;
            r_iso_n   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge value of every other, matching real flop behaviour.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_ISO_PRE;
                        r_iso_cnt <= '0;
                        r_iso_n   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_err     <= 1'b0;
                    end
                end
                S_ISO_PRE: begin
                    if (w_iso_last) begin
                        r_state   <= S_SHIFT;
                        r_iso_cnt <= '0;
                    end else begin
                        r_iso_cnt <= r_iso_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_last_shift) begin
                        r_state <= S_ISO_POST;
                    end
                end
                S_ISO_POST: begin
                    if (w_iso_last) begin
                        r_state   <= S_IDLE;
                        r_iso_cnt <= '0;
                        r_iso_n   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_iso_cnt <= r_iso_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (start && (r_state != S_IDLE)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Serialiser and readback packer; loading a word overrides the shift.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            r_bit_cnt  <= '0;
            r_words    <= '0;
            r_rem      <= '0;
            r_sr       <= '0;
            r_rb       <= '0;
            r_rb_pos   <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (w_new_session) begin
                r_bit_cnt <= '0;
                r_words   <= '0;
                r_rem     <= '0;
                r_sr      <= '0;
                r_rb      <= '0;
                r_rb_pos  <= '0;
            end else begin
                if (w_clk_en) begin
                    r_sr      <= {r_sr[30:0], 1'b0};
                    r_rem     <= r_rem - 6'd1;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    r_rb      <= w_rb_word;
                    r_rb_pos  <= r_rb_pos + 5'd1;
                    if ((r_rb_pos == 5'd31) || w_last_shift) begin
                        // The final partial word is left-justified.
                        r_rb_data  <= w_last_shift ? (w_rb_word << RB_PAD) : w_rb_word;
                        r_rb_valid <= 1'b1;
                    end
                end
                if (w_load) begin
                    r_sr    <= cfg_data;
                    r_rem   <= w_load_bits;
                    r_words <= r_words + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
`timescale 1ns/1ps
// Self-checking bench for ccff_chain_loader (CHAIN_LEN=40, ISO_CYC=4).
// The chain itself is modelled as a 40-bit FIFO driven by the DUT's head and
// clock enable. A session-level reference model predicts every output on
// every cycle; directed sessions add hand-computed literal expectations.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 40;
    localparam int ISO_CYC   = 4;
    localparam int NUM_WORDS = (CHAIN_LEN + 31) / 32;
    localparam int LAST_BITS = ((CHAIN_LEN - 1) % 32) + 1;

    logic        prog_clk;
    logic        prog_reset;
    logic        start;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        ccff_head;
    logic        chain_clk_en;
    logic        ccff_tail;
    logic [31:0] rb_data;
    logic        rb_valid;
    logic        IO_ISOL_N;
    logic        busy;
    logic        done;
    logic        err;

    ccff_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .ISO_CYC   (ISO_CYC)
    ) dut (
        .prog_clk     (prog_clk),
        .prog_reset   (prog_reset),
        .start        (start),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .ccff_head    (ccff_head),
        .chain_clk_en (chain_clk_en),
        .ccff_tail    (ccff_tail),
        .rb_data      (rb_data),
        .rb_valid     (rb_valid),
        .IO_ISOL_N    (IO_ISOL_N),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // External configuration chain: a FIFO of CHAIN_LEN flops.
    logic [CHAIN_LEN-1:0] chain;
    assign ccff_tail = chain[CHAIN_LEN-1];
    initial chain = {8'($urandom()), $urandom()};
    always @(posedge prog_clk) begin
        if (chain_clk_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end

    // Reference model state (session level).
    bit                   m_active, m_iso_n, m_err, m_done, m_rb_v;
    logic [31:0]          m_rb_exp;
    bit                   m_q[$];
    int                   m_t, m_words, m_shifts, m_post;
    logic [CHAIN_LEN-1:0] m_snap;
    bit                   u_en, u_rdy;
    int                   u_nb;

    function automatic bit exp_shift();
        return m_active && (m_t > ISO_CYC) && (m_shifts < CHAIN_LEN);
    endfunction
    function automatic bit exp_en();
        return exp_shift() && (m_q.size() > 0);
    endfunction
    function automatic bit exp_ready();
        return exp_shift() && (m_words < NUM_WORDS) && (m_q.size() <= 1);
    endfunction
    // Word k of the previous chain contents, tail bit first, zero-padded.
    function automatic logic [31:0] snap_word(input int k);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            if (32 * k + i < CHAIN_LEN) w[31-i] = m_snap[CHAIN_LEN-1-(32*k+i)];
        end
        return w;
    endfunction

    always @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            m_active = 0; m_iso_n = 0; m_err = 0; m_done = 0; m_rb_v = 0;
            m_rb_exp = '0; m_q.delete();
            m_t = 0; m_words = 0; m_shifts = 0; m_post = 0;
        end else begin
            u_en  = exp_en();
            u_rdy = exp_ready();
            m_done = 0;
            m_rb_v = 0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_iso_n = 0; m_err = 0;
                    m_t = 1; m_words = 0; m_shifts = 0; m_post = 0;
                    m_q.delete();
                    m_snap = chain;
                end
            end else begin
                if (start) m_err = 1;
                m_t++;
                if (m_shifts == CHAIN_LEN) begin
                    m_post++;
                    if (m_post == ISO_CYC) begin
                        m_active = 0; m_done = 1; m_iso_n = 1;
                    end
                end
                if (u_en) begin
                    void'(m_q.pop_front());
                    m_shifts++;
                    if ((m_shifts % 32 == 0) || (m_shifts == CHAIN_LEN)) begin
                        m_rb_v   = 1;
                        m_rb_exp = snap_word((m_shifts - 1) / 32);
                    end
                end
                if (u_rdy && cfg_valid) begin
                    u_nb = (m_words == NUM_WORDS - 1) ? LAST_BITS : 32;
                    for (int i = 0; i < u_nb; i++) m_q.push_back(cfg_data[31-i]);
                    m_words++;
                end
            end
        end
    end

    // Monitors used by the directed literal checks.
    int           mon_en;
    logic [39:0]  mon_heads;
    logic [31:0]  mon_rb[$];

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge prog_clk) begin
        check("busy", busy, m_active);
        check("io_isol_n", IO_ISOL_N, m_iso_n);
        check("done", done, m_done);
        check("err", err, m_err);
        check("chain_clk_en", chain_clk_en, exp_en());
        check("cfg_ready", cfg_ready, exp_ready());
        check("rb_valid", rb_valid, m_rb_v);
        if (exp_en()) check("ccff_head", ccff_head, m_q[0]);
        if (m_rb_v) check("rb_data", rb_data, m_rb_exp);
        if (chain_clk_en) begin
            mon_en++;
            mon_heads = {mon_heads[38:0], ccff_head};
        end
        if (rb_valid) mon_rb.push_back(rb_data);
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cfg_ready"}, cfg_ready, 1'b0);
        check({tag, "_ccff_head"}, ccff_head, 1'b0);
        check({tag, "_chain_clk_en"}, chain_clk_en, 1'b0);
        check({tag, "_rb_data"}, rb_data, 32'h0);
        check({tag, "_rb_valid"}, rb_valid, 1'b0);
        check({tag, "_io_isol_n"}, IO_ISOL_N, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    // One full session: start, then offer w0/w1. gap withholds cfg_valid for
    // that many ready cycles after w0; rnd randomises cfg_valid instead;
    // poke pulses start at that session cycle. cyc = start-to-done cycles.
    task automatic run_session(input logic [31:0] w0, input logic [31:0] w1, input int gap,
                               input bit rnd, input int poke, output int cyc);
        int          widx;
        int          gap_left;
        bit          hs;
        logic [31:0] wd[2];
        wd[0] = w0; wd[1] = w1;
        widx = 0; gap_left = 0;
        mon_en = 0; mon_heads = '0; mon_rb.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_cleared", err, 1'b0);
        cyc = 1;
        while (!done && cyc < 400) begin
            if (widx < 2) begin
                if (rnd) cfg_valid = ($urandom_range(0, 3) != 0);
                else     cfg_valid = !(widx == 1 && gap_left > 0);
                cfg_data = cfg_valid ? wd[widx] : $urandom();
                if (!rnd && widx == 1 && gap_left > 0 && cfg_ready) gap_left--;
            end else begin
                cfg_valid = 1'b0;
                cfg_data  = $urandom();
            end
            start = (poke != 0) && (cyc == poke);
            hs = cfg_valid && cfg_ready;
            tick();
            if (hs) begin
                if (widx == 0) gap_left = gap;
                widx++;
            end
            cyc++;
        end
        start = 1'b0;
        cfg_valid = 1'b0;
        check("done_seen", done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int n;
        prog_reset = 1'b1;
        start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        mon_en = 0;
        mon_heads = '0;
        tick(); tick();
        check_reset_values("por");
        prog_reset = 1'b0;
        tick();

        // First load: 40 shifts, A5A5A5A5 then FF, done after 50 cycles.
        run_session(32'hA5A5A5A5, 32'hFF000000, 0, 0, 0, cyc);
        check("load1_done_cycle", cyc, 50);
        check("load1_shift_count", mon_en, 40);
        check("load1_head_stream", mon_heads, 40'hA5A5A5A5FF);
        tick(); tick();
        check("load1_io_released", IO_ISOL_N, 1'b1);

        // Asynchronous reset mid-cycle while idle and released.
        #2 prog_reset = 1'b1;
        #1 check_reset_values("async");
        tick();
        prog_reset = 1'b0;
        tick();

        // Reload: readback returns the previous load.
        run_session(32'h12345678, 32'h9A000000, 0, 0, 0, cyc);
        check("rb_word_count", mon_rb.size(), 2);
        if (mon_rb.size() == 2) begin
            check("rb_word0", mon_rb[0], 32'hA5A5A5A5);
            check("rb_word1", mon_rb[1], 32'hFF000000);
        end

        // Stall of 5 cycles after the first word.
        run_session(32'hDEADBEEF, 32'h5A000000, 5, 0, 0, cyc);
        check("stall_done_cycle", cyc, 55);
        check("stall_shift_count", mon_en, 40);
        check("stall_head_stream", mon_heads, 40'hDEADBEEF5A);
        if (mon_rb.size() == 2) begin
            check("stall_rb_word0", mon_rb[0], 32'h12345678);
            check("stall_rb_word1", mon_rb[1], 32'h9A000000);
        end

        // Start while busy: err sticks, session unchanged.
        run_session(32'h0F0F0F0F, 32'hC3000000, 0, 0, 20, cyc);
        check("busy_start_err", err, 1'b1);
        check("busy_start_done_cycle", cyc, 50);
        check("busy_start_shift_count", mon_en, 40);
        // The next accepted start clears err (checked inside run_session).
        run_session(32'h600DF00D, 32'h81000000, 0, 0, 0, cyc);
        check("err_after_clear", err, 1'b0);

        // Reset after 17 shifted bits, then a clean session.
        mon_en = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (mon_en < 17 && n < 100) begin
            cfg_valid = 1'b1;
            cfg_data = $urandom();
            tick();
            n++;
        end
        check("abort_reached_17", mon_en, 17);
        check("abort_pre_isol", IO_ISOL_N, 1'b0);
        check("abort_pre_busy", busy, 1'b1);
        #2 prog_reset = 1'b1;
        #1 check_reset_values("abort");
        cfg_valid = 1'b0;
        tick();
        prog_reset = 1'b0;
        tick();
        run_session(32'h13579BDF, 32'h2468ACE0, 0, 0, 0, cyc);
        check("recover_shift_count", mon_en, 40);
        check("recover_done_cycle", cyc, 50);

        // Randomised sessions with random valid gaps and stray starts.
        for (int s = 0; s < 20; s++) begin
            run_session($urandom(), $urandom(), 0, 1,
                        ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 45)) : 0, cyc);
            check("rand_shift_count", mon_en, 40);
            check("rand_rb_words", mon_rb.size(), 2);
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                cfg_valid = $urandom_range(0, 1);
                cfg_data = $urandom();
                tick();
            end
            cfg_valid = 1'b0;
        end

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain writer that serializes a host bitstream into the `ccff_head` of the I/O and logic tile chain, one bit per enabled `prog_clk` cycle. It captures the bits returned on `ccff_tail` as word-aligned readback of the previous configuration. It holds the I/O tiles isolated (`IO_ISOL_N` low) for the whole programming session and releases them only after the chain is fully loaded. It sits between the bitstream host port and the fabric top, and drives the enable of the external clock gate on the chain clock.

## Interface
Parameters:
- `CHAIN_LEN`, default 1024: total configuration flops in the chain (≥1).
- `ISO_CYC`, default 4: isolation guard cycles before and after shifting (≥1).
- `CNT_W`, default $clog2(CHAIN_LEN+1): derived width of the bit counter; not overridden.

Ports:
- `prog_clk`  in  1  programming clock; all logic is on its rising edge.
- `prog_reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle request to begin a session.
- `cfg_data`  in  32  bitstream word; bit 31 is shifted first.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  block accepts the word this cycle.
- `ccff_head`  out  1  serial data to the chain head.
- `chain_clk_en`  out  1  the chain flops capture on this `prog_clk` edge (drives the external ICG).
- `ccff_tail`  in  1  serial data from the chain tail.
- `rb_data`  out  32  readback word.
- `rb_valid`  out  1  one-cycle pulse qualifying `rb_data`; no backpressure.
- `IO_ISOL_N`  out  1  I/O isolation; 0 = isolated.
- `busy`  out  1  session in progress.
- `done`  out  1  one-cycle pulse at end of session.
- `err`  out  1  sticky flag: `start` was received while busy.

## Operation
- FSM states and transitions:
  - IDLE: `start` → ISO_PRE.
  - ISO_PRE: stay `ISO_CYC` cycles → SHIFT.
  - SHIFT: run until the `CHAIN_LEN` shift count is reached → ISO_POST.
  - ISO_POST: stay `ISO_CYC` cycles → IDLE.
- `busy`=1 in every state except IDLE.
- `IO_ISOL_N` is cleared to 0 on the cycle ISO_PRE is entered and set to 1 on leaving ISO_POST. It holds its value in IDLE.
- SHIFT datapath:
  - A 32-bit shift register with a bits-remaining count. `ccff_head` = shift register bit 31.
  - `chain_clk_en` = SHIFT and bits-remaining>0.
  - On each enabled cycle: shift left, bit counter +1, and sample `ccff_tail` (the value before the edge).
- `cfg_ready` = SHIFT and words-accepted < ceil(`CHAIN_LEN`/32) and (bits-remaining==0, or bits-remaining==1 with `chain_clk_en`). A continuous `cfg_valid` therefore gives 1 bit/cycle with no bubbles.
- The last word loads only `CHAIN_LEN` mod 32 bits (32 if zero). Its low-order excess bits are discarded and never shifted.
- `cfg_valid` low while the shift register is empty: `chain_clk_en`=0 and the counter holds (stall).
- Readback:
  - Sampled tail bits enter `rb` register at the LSB, MSB-first order.
  - Every 32nd sample pulses `rb_valid` with the completed word.
  - The final partial word pulses on the last shift cycle, left-justified and zero-padded in its low bits.
  - Readback word k equals word k of the previous load (chain is FIFO-ordered).
- `start` outside IDLE: ignored, `err`←1. `err` clears only when a `start` is accepted in IDLE.
- Reset values: `cfg_ready`=0, `ccff_head`=0, `chain_clk_en`=0, `rb_data`=0, `rb_valid`=0, `IO_ISOL_N`=0 (chain contents unknown), `busy`=0, `done`=0, `err`=0, FSM=IDLE.
- Reset mid-session: abort immediately to the reset values. A partial chain load is abandoned. Recovery requires a fresh `start`.

## Timing
- `start` at edge 0 → ISO_PRE cycles 1..`ISO_CYC`, with `IO_ISOL_N`=0 from cycle 1.
- SHIFT from cycle `ISO_CYC`+1. `cfg_ready` may assert in the first SHIFT cycle.
- A word accepted at edge t drives its bit 31 on `ccff_head` with `chain_clk_en`=1 in cycle t+1.
- With no stalls, SHIFT lasts `CHAIN_LEN`+1 cycles: one load cycle plus `CHAIN_LEN` shift cycles.
- ISO_POST lasts `ISO_CYC` cycles. `done`=1 and `IO_ISOL_N`→1 in the cycle after ISO_POST ends; `busy` falls on that same edge.
- Total session with no stalls: 2·`ISO_CYC`+`CHAIN_LEN`+2 cycles from `start` to `done`.
- `rb_valid` is registered: it asserts one cycle after the enabled edge that sampled the word's last bit.

## Test plan
Use `CHAIN_LEN`=40 and `ISO_CYC`=4 unless stated otherwise.
1. **Reset values:** assert `prog_reset` asynchronously mid-cycle → all outputs at their reset values immediately; `IO_ISOL_N`=0.
2. **First load:** `start`, then words 0xA5A5A5A5 and 0xFF000000 with `cfg_valid` held high.
   - Exactly 40 `chain_clk_en` cycles.
   - `ccff_head` sequence is 1010… (32 bits), then 11111111.
   - `done` 50 cycles after `start`; `IO_ISOL_N`=1 from then on.
3. **Readback:** reload with 0x12345678 and 0x9A000000 → `rb_valid` pulses twice, with `rb_data`=0xA5A5A5A5, then 0xFF000000.
4. **Stalls:** deassert `cfg_valid` for 5 cycles after the first word → no bubble until that word is drained, then `chain_clk_en`=0 for the gap. The count still totals 40; `done` is delayed by 5 cycles.
5. **Start while busy:** `start` during SHIFT → `err`=1 and the session completes unchanged. A later `start` in IDLE clears `err`.
6. **Reset mid-shift:** `prog_reset` after 17 shifted bits → `IO_ISOL_N`=0, `busy`=0. A following `start` takes exactly 40 shifts and returns `done`.
